// File: rtl/rounding_pkg.sv
// Shared rounding definitions: mode codes, per-result flag bundle and increment decision.
package rounding_pkg;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_mode_e;

  typedef struct packed {
    logic inexact;
    logic overflow;
    logic underflow;
  } round_flags_t;

  // Codes 6 and 7 fall through to round-to-nearest-even.
  function automatic logic round_incr(input logic [2:0] mode, input logic sign, input logic lsb,
                                      input logic guard, input logic sticky);
    logic incr;
    case (round_mode_e'(mode))
      IEEE_zero: incr = 1'b0;
      IEEE_pinf: incr = !sign & (guard | sticky);
      IEEE_ninf: incr = sign & (guard | sticky);
      near_up:   incr = guard;
      away_zero: incr = guard | sticky;
      default:   incr = guard & (sticky | lsb);
    endcase
    return incr;
  endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Combinational round-increment decision and mantissa add, one bit wider to expose carry-out.
module fp_round_incr
  import rounding_pkg::*;
#(
  parameter int unsigned MAN_W = 23
) (
  input  logic [MAN_W:0]   mant_i,
  input  logic             sign_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic [2:0]       mode_i,
  output logic [MAN_W+1:0] mant_o,
  output logic             inexact_o
);

  logic incr;

  assign incr      = round_incr(mode_i, sign_i, mant_i[0], guard_i, sticky_i);
  assign mant_o    = {1'b0, mant_i} + {{(MAN_W + 1){1'b0}}, incr};
  assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 round/pack pipeline with valid/ready flow control.
// Optional accumulated sticky flags are enabled with `define ROUND_FLAG_ACC_EN.
module fp_round_pipe
  import rounding_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exponent,
  input  logic [MAN_W:0]           in_mantissa,
  input  logic                     in_guard,
  input  logic                     in_sticky,
  input  logic [2:0]               in_round_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_z,
  output logic                     out_inexact,
  output logic                     out_overflow,
  output logic                     out_underflow,
  input  logic                     flag_clr,
  output logic                     acc_inexact,
  output logic                     acc_overflow,
  output logic                     acc_underflow
);

  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned ZW = EXP_W + MAN_W + 1;
  localparam logic [EW-1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};

  logic [MAN_W+1:0] mant_rnd;
  logic             inexact_rnd;

  logic             s1_valid_q, s1_sign_q, s1_inexact_q;
  logic [EW-1:0]    s1_exp_q;
  logic [MAN_W+1:0] s1_mant_q;
  logic [2:0]       s1_mode_q;

  logic             s2_valid_q;
  logic [ZW-1:0]    z_d, z_q;
  round_flags_t     flags_d, flags_q;

  logic             s1_load, s2_load, carry, ovf, unf;
  logic [EW:0]      exp_rnd;
  logic [ZW-1:0]    inf_z, maxn_z;

  fp_round_incr #(
    .MAN_W(MAN_W)
  ) u_incr (
    .mant_i   (in_mantissa),
    .sign_i   (in_sign),
    .guard_i  (in_guard),
    .sticky_i (in_sticky),
    .mode_i   (in_round_mode),
    .mant_o   (mant_rnd),
    .inexact_o(inexact_rnd)
  );

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load && !rst;

  always_comb begin
    carry   = s1_mant_q[MAN_W+1];
    // Sign-extend one bit so the carry increment can never wrap.
    exp_rnd = {s1_exp_q[EW-1], s1_exp_q} + {{EW{1'b0}}, carry};
    ovf     = !exp_rnd[EW] && (exp_rnd[EW-1:0] >= ExpMax);
    unf     = exp_rnd[EW] || (exp_rnd == '0);
    inf_z   = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    maxn_z  = {s1_sign_q, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    z_d     = {s1_sign_q, exp_rnd[EXP_W-1:0],
               carry ? s1_mant_q[MAN_W:1] : s1_mant_q[MAN_W-1:0]};
    flags_d = '{inexact: s1_inexact_q, overflow: 1'b0, underflow: 1'b0};

    if (ovf) begin
      flags_d = '{inexact: 1'b1, overflow: 1'b1, underflow: 1'b0};
      case (round_mode_e'(s1_mode_q))
        IEEE_zero: z_d = maxn_z;
        IEEE_pinf: z_d = s1_sign_q ? maxn_z : inf_z;
        IEEE_ninf: z_d = s1_sign_q ? inf_z : maxn_z;
        default:   z_d = inf_z;
      endcase
    end else if (unf) begin
      flags_d = '{inexact: 1'b1, overflow: 1'b0, underflow: 1'b1};
      z_d     = {s1_sign_q, {(ZW - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_inexact_q <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_mode_q    <= '0;
      s2_valid_q   <= 1'b0;
      z_q          <= '0;
      flags_q      <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q   <= in_valid;
        s1_sign_q    <= in_sign;
        s1_inexact_q <= inexact_rnd;
        s1_exp_q     <= in_exponent;
        s1_mant_q    <= mant_rnd;
        s1_mode_q    <= in_round_mode;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        z_q        <= z_d;
        flags_q    <= flags_d;
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_z         = z_q;
  assign out_inexact   = flags_q.inexact;
  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;

`ifdef ROUND_FLAG_ACC_EN
  round_flags_t acc_d, acc_q;

  // A transfer coinciding with a clear leaves exactly that result's flags.
  always_comb begin
    acc_d = flag_clr ? '0 : acc_q;
    if (out_valid && out_ready) acc_d = round_flags_t'(acc_d | flags_q);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_inexact   = acc_q.inexact;
  assign acc_overflow  = acc_q.overflow;
  assign acc_underflow = acc_q.underflow;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign acc_inexact     = 1'b0;
  assign acc_overflow    = 1'b0;
  assign acc_underflow   = 1'b0;
`endif

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined IEEE-754 rounding and packing stage, the successor to the combinational multiplier rounding step. It takes a normalised sign/exponent/mantissa result with guard and sticky bits, applies one of six rounding modes, renormalises on carry-out, and detects overflow and underflow. It packs the final word and raises status flags. It sits after the normaliser of any FP datapath (multiplier, adder) behind a valid/ready handshake, with a throughput of one result per cycle.

## Interface
- EXP_W, 8: biased exponent field width.
- MAN_W, 23: stored fraction width. The internal mantissa is MAN_W+1 bits, including the hidden bit.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept an input this cycle
- in_sign  in  1  sign
- in_exponent  in  EXP_W+2  biased exponent, two's-complement signed
- in_mantissa  in  MAN_W+1  normalised mantissa, MSB is the hidden bit
- in_guard, in_sticky  in  1 each  round and sticky bits
- in_round_mode  in  3  rounding_pkg mode code
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_z  out  EXP_W+MAN_W+1  packed result
- out_inexact, out_overflow, out_underflow  out  1 each  per-result flags
- flag_clr  in  1  clears the accumulated flags
- acc_inexact, acc_overflow, acc_underflow  out  1 each  accumulated sticky flags

## Operation
- Increment decision, per mode:
  - IEEE_near: guard & (sticky | lsb).
  - IEEE_zero: never increment.
  - IEEE_pinf: !sign & (guard|sticky).
  - IEEE_ninf: sign & (guard|sticky).
  - near_up: guard (ties away from zero).
  - away_zero: guard|sticky.
  - Undefined codes behave as IEEE_near.
- Mantissa is extended to MAN_W+2 bits before the increment. On carry-out, the mantissa is shifted right by 1 and the exponent incremented.
- inexact = guard|sticky, before any overflow or underflow forcing.
- Overflow: rounded exponent ≥ 2^EXP_W−1. Sets overflow=1 and inexact=1. Result by mode:
  - IEEE_near, near_up, away_zero: ±inf.
  - IEEE_zero: ±max-normal.
  - IEEE_pinf: +inf if positive, −max-normal if negative.
  - IEEE_ninf: the mirror of IEEE_pinf.
- Underflow: rounded exponent ≤ 0. The result flushes to signed zero, with underflow=1 and inexact=1. Subnormals are not produced.
- Otherwise, out_z = {sign, exponent[EXP_W−1:0], mantissa[MAN_W−1:0]}.

## Timing
- Two register stages:
  - S1 latches the inputs and the increment result.
  - S2 holds the normalised, overflow-checked, packed result plus flags.
- Latency is 2 cycles from input acceptance (in_valid & in_ready) to out_valid.
- Throughput is 1 per cycle while out_ready=1.
- Stage advance rules:
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - in_ready = S1 loads.
- Outputs are held stable while out_valid & !out_ready. Nothing is dropped or duplicated, and order is preserved.
- Reset, synchronous, with all valids cleared:
  - out_valid=0 and in_ready=0 while rst=1.
  - out_z and all flags are 0.
  - acc_* are 0.
- A reset during operation discards both stages' contents on the next edge.

## Configuration
- ROUND_FLAG_ACC_EN defined:
  - acc_* OR in the out_* flags of each transferred result (out_valid & out_ready).
  - flag_clr=1 clears them.
  - Simultaneous clr and transfer: the acc_* value equals that result's flags, so the set wins.
- ROUND_FLAG_ACC_EN undefined: the acc_* ports are tied to 0 and flag_clr is ignored.

## Structure
- rounding_pkg holds:
  - the round-mode enum (IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero);
  - a round_flags_t struct (inexact, overflow, underflow);
  - a function computing the increment decision.
- One sub-module, fp_round_incr: combinational increment decision plus mantissa add, feeding S1.

## Test plan
All scenarios use EXP_W=8 and MAN_W=23.
- Carry renormalisation: mant=0xFFFFFF, exp=127, guard=1, sticky=0, IEEE_near → z=0x40000000, inexact=1.
- Ties:
  - mant=0x800000, exp=127, guard=1, sticky=0, IEEE_near → z=0x3F800000.
  - Same input with near_up → z=0x3F800001.
- Overflow: exp=254, mant=0xFFFFFF, guard=1.
  - IEEE_near → 0x7F800000, overflow=1.
  - IEEE_zero → 0x7F7FFFFF.
  - Sign=1 with IEEE_pinf → 0xFF7FFFFF.
- Underflow: exp=0, sign=1 → z=0x80000000, underflow=1, inexact=1.
- Backpressure:
  - 4 back-to-back inputs with out_ready held low for 3 cycles → in_ready drops once both stages are full.
  - All 4 results emerge in order with no loss; latency is 2 when unstalled.
- Flag accumulation, with ROUND_FLAG_ACC_EN defined:
  - After the overflow case, acc_overflow=1 until flag_clr is asserted.
  - flag_clr asserted together with an inexact transfer → acc_inexact=1.
  - Mid-stream rst → out_valid=0 and acc_*=0 on the next cycle.
